// File: rtl/modsq_result_normalizer_if.sv
// Bus between the modsq wrapper output, the result normalizer and the host readback side.
// Handshake: in_valid is a 1-cycle pulse taken only while in_ready=1 (otherwise dropped and flagged
// in overrun); out_valid holds out_data/out_carry/out_fmt_err stable until the cycle out_ready=1.
interface modsq_result_normalizer_if #(
  parameter int NUM_ELEMENTS = 65,
  parameter int WORD_LEN     = 16
);
  logic                                  in_valid;
  logic [NUM_ELEMENTS*2*WORD_LEN-1:0]    sq_in_coefs;
  logic                                  in_ready;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [NUM_ELEMENTS*WORD_LEN-1:0]      out_data;
  logic [1:0]                            out_carry;
  logic                                  out_fmt_err;
  logic                                  overrun;
  logic [1:0]                            state_dbg;

  modport slave (
    input  in_valid, sq_in_coefs, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_fmt_err, overrun, state_dbg
  );

  modport master (
    output in_valid, sq_in_coefs, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_fmt_err, overrun, state_dbg
  );
endinterface

// File: rtl/modsq_result_normalizer.sv
// Turns the redundant modsq coefficient vector back into a plain integer by propagating
// carries word-serially, ELEMS_PER_CYCLE coefficients per clock.
module modsq_result_normalizer #(
  parameter int MOD_LEN         = 1024,
  parameter int WORD_LEN        = 16,
  parameter int COEF_BITS       = 17,
  parameter int ELEMS_PER_CYCLE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  modsq_result_normalizer_if.slave   bus
);
  localparam int NUM_ELEMENTS = MOD_LEN / WORD_LEN + 1;
  localparam int SLOT_W       = 2 * WORD_LEN;
  localparam int NCHUNK       = (NUM_ELEMENTS + ELEMS_PER_CYCLE - 1) / ELEMS_PER_CYCLE;
  localparam int NPAD         = NCHUNK * ELEMS_PER_CYCLE;
  localparam int CHUNK_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IDX_W        = $clog2(NPAD + 1);
  localparam int SUM_W        = COEF_BITS + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]                              state;
  logic [NPAD-1:0][COEF_BITS-1:0]          coef_q;
  logic [CHUNK_W-1:0]                      chunk_q;
  logic [1:0]                              carry_q;
  logic                                    fmt_err_q;
  logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]   data_q;
  logic [1:0]                              out_carry_q;
  logic                                    out_fmt_err_q;
  logic                                    out_valid_q;
  logic                                    overrun_q;

  // Coefficient array is padded to whole chunks; pad entries stay zero so the tail chunk reads are harmless.
  logic [NPAD-1:0][COEF_BITS-1:0]          coef_in;
  logic                                    fmt_in;

  always_comb begin
    coef_in = '0;
    fmt_in  = 1'b0;
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      coef_in[j] = bus.sq_in_coefs[j*SLOT_W +: COEF_BITS];
      fmt_in     = fmt_in | (|bus.sq_in_coefs[j*SLOT_W+COEF_BITS +: SLOT_W-COEF_BITS]);
    end
  end

  logic [ELEMS_PER_CYCLE-1:0][IDX_W-1:0]    idx_c;
  logic [ELEMS_PER_CYCLE-1:0][WORD_LEN-1:0] word_c;
  logic [ELEMS_PER_CYCLE-1:0]               live_c;
  logic [1:0]                               carry_c;
  logic [SUM_W-1:0]                         sum_c;

  // Carry ripples through the chunk in one cycle; it never exceeds 2, so 2 bits suffice.
  always_comb begin
    carry_c = carry_q;
    sum_c   = '0;
    idx_c   = '0;
    word_c  = '0;
    live_c  = '0;
    for (int e = 0; e < ELEMS_PER_CYCLE; e++) begin
      idx_c[e]  = IDX_W'(chunk_q) * IDX_W'(ELEMS_PER_CYCLE) + IDX_W'(e);
      live_c[e] = (idx_c[e] < IDX_W'(NUM_ELEMENTS));
      sum_c     = {1'b0, coef_q[idx_c[e]]} + SUM_W'(carry_c);
      word_c[e] = sum_c[WORD_LEN-1:0];
      if (live_c[e]) carry_c = sum_c[WORD_LEN +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      coef_q        <= '0;
      chunk_q       <= '0;
      carry_q       <= '0;
      fmt_err_q     <= 1'b0;
      data_q        <= '0;
      out_carry_q   <= '0;
      out_fmt_err_q <= 1'b0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (bus.in_valid && (state != IDLE)) overrun_q <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            coef_q    <= coef_in;
            fmt_err_q <= fmt_in;
            carry_q   <= '0;
            chunk_q   <= '0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          for (int e = 0; e < ELEMS_PER_CYCLE; e++) begin
            if (live_c[e]) data_q[idx_c[e]] <= word_c[e];
          end
          carry_q <= carry_c;
          chunk_q <= chunk_q + CHUNK_W'(1);
          if (chunk_q == CHUNK_W'(NCHUNK - 1)) begin
            out_carry_q   <= carry_c;
            out_fmt_err_q <= fmt_err_q;
            out_valid_q   <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_carry   = out_carry_q;
  assign bus.out_fmt_err = out_fmt_err_q;
  assign bus.overrun     = overrun_q;
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_modsq_result_normalizer.sv
// Self-checking bench for modsq_result_normalizer: random and directed coefficient vectors against
// a big-integer reference sum, plus backpressure, overrun and mid-operation reset scenarios.
module tb_modsq_result_normalizer;
  localparam int NE  = 65;
  localparam int W   = 16;
  localparam int NCH = 17;
  localparam int AW  = NE * W + 2;
  localparam int RW  = AW + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  modsq_result_normalizer_if #(.NUM_ELEMENTS(NE), .WORD_LEN(W)) bus();
  modsq_result_normalizer dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [31:0]   slot_v [NE];
  logic [RW-1:0] exp_q [$];

  // Result packed as {carry, data, fmt_err}; value is the plain sum of masked coefficients.
  function automatic logic [RW-1:0] model();
    logic [AW-1:0] acc;
    logic          err;
    acc = '0;
    err = 1'b0;
    for (int j = 0; j < NE; j++) begin
      acc = acc + (AW'(slot_v[j][16:0]) << (W * j));
      err = err | (|slot_v[j][31:17]);
    end
    return {acc, err};
  endfunction

  task automatic show_diff(input string name, input logic [RW-1:0] g, input logic [RW-1:0] e);
    int k = NE;
    for (int i = 0; i < NE; i++) if (g[1+W*i +: W] !== e[1+W*i +: W]) begin k = i; break; end
    if (k < NE) $display("FAIL %s word %0d got %h exp %h", name, k, g[1+W*k +: W], e[1+W*k +: W]);
    else $display("FAIL %s carry/fmt got %h/%b exp %h/%b", name, g[RW-1 -: 2], g[0], e[RW-1 -: 2], e[0]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_op();
    @(negedge clk);
    for (int j = 0; j < NE; j++) bus.sq_in_coefs[j*32 +: 32] = slot_v[j];
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(output int lat, output logic [RW-1:0] got);
    lat = -1;
    got = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin lat = n; break; end
    end
    if (lat > 0) got = {bus.out_carry, bus.out_data, bus.out_fmt_err};
  endtask

  task automatic release_hs();
    @(posedge clk); #1;
  endtask

  task automatic fill(input int p);
    for (int j = 0; j < NE; j++) begin
      case (p)
        0: slot_v[j] = 32'h0;
        1: slot_v[j] = (j == 0) ? 32'h1FFFF : 32'h0;
        2: slot_v[j] = 32'h1FFFF;
        3: slot_v[j] = (j == 5) ? 32'h0002_0003 : 32'h0;
        default: begin
          case ($urandom_range(0, 3))
            0: slot_v[j] = 32'h1FFFF;
            1: slot_v[j] = 32'h1FFFE;
            default: slot_v[j] = $urandom_range(0, 32'h1FFFF);
          endcase
          if ($urandom_range(0, 40) == 0) slot_v[j] = slot_v[j] | ($urandom & 32'hFFFE_0000);
        end
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.sq_in_coefs = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got nonzero exp 0"); end
    checks++; if (bus.out_carry !== 2'd0) begin failures++; $display("FAIL reset_out_carry got %0d exp 0", bus.out_carry); end
    checks++; if (bus.out_fmt_err !== 1'b0) begin failures++; $display("FAIL reset_fmt_err got %b exp 0", bus.out_fmt_err); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
    checks++; if (bus.state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got %0d exp 0", bus.state_dbg); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Directed patterns 0..3 then random vectors, each issued back-to-back after the previous handshake.
  task automatic test_patterns();
    int lat;
    logic [RW-1:0] got, exp;
    bus.out_ready = 1'b1;
    for (int p = 0; p < 12; p++) begin
      fill(p);
      exp_q.push_back(model());
      send_op();
      collect(lat, got);
      exp = exp_q.pop_front();
      checks++; if (lat !== NCH) begin failures++; $display("FAIL pattern%0d_latency got %0d exp %0d", p, lat, NCH); end
      checks++; if (got !== exp) begin failures++; show_diff($sformatf("pattern%0d_result", p), got, exp); end
      if (p == 2) begin
        checks++; if (got[RW-1 -: 2] !== 2'd2) begin failures++; $display("FAIL allmax_carry got %0d exp 2", got[RW-1 -: 2]); end
      end
      if (p == 3) begin
        checks++; if (got[1+W*5 +: W] !== 16'h0003 || got[0] !== 1'b1) begin
          failures++; $display("FAIL fmt_word5 got %h/%b exp 0003/1", got[1+W*5 +: W], got[0]);
        end
      end
      release_hs();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++; $display("FAIL pattern%0d_release got v=%b r=%b exp v=0 r=1", p, bus.out_valid, bus.in_ready);
      end
      checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL pattern%0d_overrun got %b exp 0", p, bus.overrun); end
    end
  endtask

  task automatic test_backpressure();
    int lat, bad;
    logic [RW-1:0] got, exp, now;
    bus.out_ready = 1'b0;
    fill(4);
    exp_q.push_back(model());
    send_op();
    collect(lat, got);
    checks++; if (lat !== NCH) begin failures++; $display("FAIL hold_latency got %0d exp %0d", lat, NCH); end
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 10) begin
        bus.sq_in_coefs = {NE{32'h0000_1234}};
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      now = {bus.out_carry, bus.out_data, bus.out_fmt_err};
      if (now !== got || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable got %0d unstable cycles exp 0", bad); end
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL hold_overrun got %b exp 1", bus.overrun); end
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; show_diff("hold_result", got, exp); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    release_hs();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL hold_release got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready);
    end
    now = {bus.out_carry, bus.out_data, bus.out_fmt_err};
    checks++; if (now !== exp) begin failures++; show_diff("hold_data_kept", now, exp); end
  endtask

  task automatic test_handshake_collision();
    int lat, stale;
    logic [RW-1:0] got, exp;
    apply_reset();
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL collide_reset_overrun got %b exp 0", bus.overrun); end
    bus.out_ready = 1'b0;
    fill(5);
    exp_q.push_back(model());
    send_op();
    collect(lat, got);
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; show_diff("collide_result", got, exp); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.overrun !== 1'b1) begin
      failures++; $display("FAIL collide_drop got v=%b r=%b ov=%b exp v=0 r=1 ov=1", bus.out_valid, bus.in_ready, bus.overrun);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    stale = 0;
    repeat (25) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) stale++; end
    checks++; if (stale != 0) begin failures++; $display("FAIL collide_no_result got %0d valid cycles exp 0", stale); end
  endtask

  task automatic test_reset_mid_accum();
    int lat, stale;
    logic [RW-1:0] got, exp;
    bus.out_ready = 1'b1;
    fill(6);
    send_op();
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.overrun !== 1'b0 || bus.state_dbg !== 2'd0) begin
      failures++; $display("FAIL midreset_state got v=%b r=%b ov=%b st=%0d exp v=0 r=1 ov=0 st=0",
                           bus.out_valid, bus.in_ready, bus.overrun, bus.state_dbg);
    end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL midreset_data got nonzero exp 0"); end
    stale = 0;
    repeat (25) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) stale++; end
    checks++; if (stale != 0) begin failures++; $display("FAIL midreset_stale got %0d valid cycles exp 0", stale); end
    for (int j = 0; j < NE; j++) slot_v[j] = 32'h1;
    exp_q.push_back(model());
    send_op();
    collect(lat, got);
    exp = exp_q.pop_front();
    checks++; if (lat !== NCH) begin failures++; $display("FAIL midreset_latency got %0d exp %0d", lat, NCH); end
    checks++; if (got !== exp) begin failures++; show_diff("midreset_result", got, exp); end
    checks++; if (got[1+W*64 +: W] !== 16'h0001 || got[1 +: W] !== 16'h0001) begin
      failures++; $display("FAIL midreset_words got %h/%h exp 0001/0001", got[1 +: W], got[1+W*64 +: W]);
    end
    release_hs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_patterns();
    test_backpressure();
    test_handshake_collision();
    test_reset_mid_accum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
